// File: rtl/issue_stage_pkg.sv
// Issue-stage shared types: the decoded payload that travels from
// decode through rename and dispatch.
package issue_stage_pkg;
  localparam int ARCH_ADDR_WIDTH = 5;
  localparam int PC_WIDTH_DEF = 32;

  typedef struct packed {
    logic [ARCH_ADDR_WIDTH-1:0] rs1_arch;
    logic [ARCH_ADDR_WIDTH-1:0] rs2_arch;
    logic [ARCH_ADDR_WIDTH-1:0] rd_arch;
    logic rd_write_enable;
    logic branch;
    logic load_store;
    logic [PC_WIDTH_DEF-1:0] pc;
  } rename_entry_t;
endpackage

// File: rtl/decode_rename_buffer_if.sv
// Decode-to-rename handshake bundle: 3-wide push from decode, 3-wide
// grant/pop toward the RAT.
interface decode_rename_buffer_if;
  import issue_stage_pkg::*;

  logic [2:0] in_valid;
  rename_entry_t in_entry_0;
  rename_entry_t in_entry_1;
  rename_entry_t in_entry_2;
  logic in_ready;
  rename_entry_t out_entry_0;
  rename_entry_t out_entry_1;
  rename_entry_t out_entry_2;
  logic [2:0] out_valid;
  logic [2:0] rename_ready;
  logic [2:0] lsq_alloc_ready;

  modport slave (
    input  in_valid, in_entry_0, in_entry_1, in_entry_2,
    input  rename_ready, lsq_alloc_ready,
    output in_ready, out_valid,
    output out_entry_0, out_entry_1, out_entry_2
  );

  modport master (
    output in_valid, in_entry_0, in_entry_1, in_entry_2,
    output rename_ready, lsq_alloc_ready,
    input  in_ready, out_valid,
    input  out_entry_0, out_entry_1, out_entry_2
  );
endinterface

// File: rtl/decode_rename_buffer.sv
// In-order circular buffer between the 3-wide decoder and the RAT;
// out_valid is both the grant and the pop.
module decode_rename_buffer
  import issue_stage_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  decode_rename_buffer_if.slave bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("decode_rename_buffer: DEPTH must be a power of two >= 4");
  end
  if (PC_WIDTH != PC_WIDTH_DEF) begin : g_bad_pc
    $error("decode_rename_buffer: PC_WIDTH must match rename_entry_t");
  end

  rename_entry_t mem [DEPTH];
  rename_entry_t in_ent [3];
  rename_entry_t view [3];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [1:0] k;
  logic [1:0] p;
  logic [1:0] lsq_avail;
  logic [1:0] ls_cnt;
  logic [2:0] grant;
  logic chain;
  logic in_ready;

  assign in_ent[0] = bus.in_entry_0;
  assign in_ent[1] = bus.in_entry_1;
  assign in_ent[2] = bus.in_entry_2;

  // Registered occupancy only, so in_ready never waits on the RAT.
  assign in_ready = occupancy <= OW'(DEPTH - 3);
  assign bus.in_ready = in_ready;

  assign k = in_ready ? 2'(bus.in_valid[0]) + 2'(bus.in_valid[1])
                        + 2'(bus.in_valid[2]) : 2'd0;
  assign lsq_avail = 2'(bus.lsq_alloc_ready[0])
                   + 2'(bus.lsq_alloc_ready[1])
                   + 2'(bus.lsq_alloc_ready[2]);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      view[i] = mem[head + AW'(i)];
    end
  end

  // Grant chain: a slot needs a free preg, enough LSQ slots for every
  // memory op up to and including it, and all older slots granted.
  always_comb begin
    grant = '0;
    ls_cnt = '0;
    chain = !flush;
    for (int i = 0; i < 3; i++) begin
      ls_cnt = ls_cnt + 2'(view[i].load_store);
      chain = chain && (OW'(i) < occupancy)
              && bus.rename_ready[i] && (ls_cnt <= lsq_avail);
      grant[i] = chain;
    end
  end

  assign p = 2'(grant[0]) + 2'(grant[1]) + 2'(grant[2]);

  assign bus.out_valid = grant;
  assign bus.out_entry_0 = view[0];
  assign bus.out_entry_1 = view[1];
  assign bus.out_entry_2 = view[2];

  assign empty = occupancy == '0;
  assign full = occupancy == OW'(DEPTH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      occupancy <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occupancy <= '0;
    end else begin
      head <= head + AW'(p);
      tail <= tail + AW'(k);
      occupancy <= occupancy + OW'(k) - OW'(p);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !flush) begin
      for (int i = 0; i < 3; i++) begin
        if (2'(i) < k) mem[tail + AW'(i)] <= in_ent[i];
      end
    end
  end

  a_in_contig: assert property (@(posedge clk) disable iff (!reset)
    (bus.in_valid & (bus.in_valid + 3'd1)) == 3'd0);
  a_out_contig: assert property (@(posedge clk) disable iff (!reset)
    (grant & (grant + 3'd1)) == 3'd0);
endmodule

// File: tb/tb_decode_rename_buffer.sv
// Scoreboard bench: a queue-based model predicts each cycle's grant and
// status; a monitor pops predictions and compares them against the DUT.
module tb_decode_rename_buffer;
  import issue_stage_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [3:0] occupancy;
  logic empty;
  logic full;

  decode_rename_buffer_if bus();

  decode_rename_buffer #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .bus(bus),
    .occupancy(occupancy),
    .empty(empty),
    .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic [2:0] ov;
    int occ;
    logic rdy;
    logic emp;
    logic ful;
    rename_entry_t e0;
    rename_entry_t e1;
    rename_entry_t e2;
  } exp_t;

  exp_t sb[$];
  rename_entry_t model[$];
  bit live = 0;
  bit drv_done = 0;
  bit mon_done = 0;
  int compared = 0;
  int mismatched = 0;

  function automatic rename_entry_t mk(input logic [31:0] pc, input logic ls);
    rename_entry_t e;
    e.rs1_arch = 5'($urandom);
    e.rs2_arch = 5'($urandom);
    e.rd_arch = 5'($urandom);
    e.rd_write_enable = 1'($urandom);
    e.branch = 1'($urandom);
    e.load_store = ls;
    e.pc = pc;
    return e;
  endfunction

  function automatic void chk(input string tag, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
    end
  endfunction

  task automatic drive(input string tag, input logic rst, input logic fl,
                       input logic [2:0] iv,
                       input rename_entry_t e0, input rename_entry_t e1,
                       input rename_entry_t e2,
                       input logic [2:0] rr, input logic [2:0] lr);
    exp_t x;
    rename_entry_t ins [3];
    int n;
    int ls;
    int avail;
    bit ready;
    @(negedge clk);
    reset = rst;
    flush = fl;
    bus.in_valid = iv;
    bus.in_entry_0 = e0;
    bus.in_entry_1 = e1;
    bus.in_entry_2 = e2;
    bus.rename_ready = rr;
    bus.lsq_alloc_ready = lr;
    #1;
    ins = '{e0, e1, e2};
    n = 0;
    if (!fl) begin
      ls = 0;
      avail = $countones(lr);
      for (int i = 0; i < 3 && i < model.size(); i++) begin
        ls += int'(model[i].load_store);
        if (!rr[i] || ls > avail) break;
        n++;
      end
    end
    ready = (DEPTH - model.size()) >= 3;
    if (live) begin
      x.tag = tag;
      x.ov = 3'((1 << n) - 1);
      x.occ = model.size();
      x.rdy = ready;
      x.emp = model.size() == 0;
      x.ful = model.size() == DEPTH;
      x.e0 = model.size() > 0 ? model[0] : '0;
      x.e1 = model.size() > 1 ? model[1] : '0;
      x.e2 = model.size() > 2 ? model[2] : '0;
      sb.push_back(x);
    end
    if (!rst) begin
      model.delete();
      live = 1;
    end else if (fl) begin
      model.delete();
    end else begin
      repeat (n) void'(model.pop_front());
      if (ready) begin
        for (int i = 0; i < $countones(iv); i++) model.push_back(ins[i]);
      end
    end
  endtask

  task automatic idle(input string tag, input logic [2:0] rr, input logic [2:0] lr);
    drive(tag, 1'b1, 1'b0, 3'b000, mk(0, 0), mk(0, 0), mk(0, 0), rr, lr);
  endtask

  task automatic push(input string tag, input logic [2:0] iv,
                      input logic [31:0] pc, input logic [2:0] ls,
                      input logic [2:0] rr, input logic [2:0] lr);
    drive(tag, 1'b1, 1'b0, iv, mk(pc, ls[0]), mk(pc + 4, ls[1]),
          mk(pc + 8, ls[2]), rr, lr);
  endtask

  initial begin
    exp_t x;
    int idle_cnt;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() == 0) begin
        if (drv_done) break;
        idle_cnt++;
        if (idle_cnt > 200) begin
          mismatched++;
          $display("FAIL monitor: no prediction for %0d cycles", idle_cnt);
          break;
        end
        continue;
      end
      idle_cnt = 0;
      x = sb.pop_front();
      chk(x.tag, "out_valid", 64'(bus.out_valid), 64'(x.ov));
      chk(x.tag, "occupancy", 64'(occupancy), 64'(x.occ));
      chk(x.tag, "in_ready", 64'(bus.in_ready), 64'(x.rdy));
      chk(x.tag, "empty", 64'(empty), 64'(x.emp));
      chk(x.tag, "full", 64'(full), 64'(x.ful));
      if (x.ov[0]) chk(x.tag, "slot0", 64'(bus.out_entry_0), 64'(x.e0));
      if (x.ov[1]) chk(x.tag, "slot1", 64'(bus.out_entry_1), 64'(x.e1));
      if (x.ov[2]) chk(x.tag, "slot2", 64'(bus.out_entry_2), 64'(x.e2));
    end
    mon_done = 1;
  end

  initial begin
    int k;
    bus.in_valid = '0;
    bus.rename_ready = '0;
    bus.lsq_alloc_ready = '0;
    bus.in_entry_0 = '0;
    bus.in_entry_1 = '0;
    bus.in_entry_2 = '0;

    drive("rst", 1'b0, 1'b0, 3'b000, mk(0, 0), mk(0, 0), mk(0, 0), 3'b000, 3'b111);
    drive("rst", 1'b0, 1'b0, 3'b000, mk(0, 0), mk(0, 0), mk(0, 0), 3'b000, 3'b111);
    idle("after_rst", 3'b111, 3'b111);

    push("basic_push", 3'b111, 32'h100, 3'b000, 3'b111, 3'b111);
    idle("basic_pop", 3'b111, 3'b111);
    idle("basic_empty", 3'b111, 3'b111);

    push("partial_fill", 3'b111, 32'h200, 3'b000, 3'b000, 3'b111);
    idle("partial_001", 3'b001, 3'b111);
    idle("partial_000", 3'b000, 3'b111);
    idle("partial_drain", 3'b111, 3'b111);

    push("lsq_fill", 3'b111, 32'h300, 3'b101, 3'b000, 3'b111);
    idle("lsq_limit", 3'b111, 3'b001);
    idle("lsq_rest", 3'b111, 3'b001);
    idle("lsq_empty", 3'b111, 3'b111);

    push("wrap_a", 3'b111, 32'h400, 3'b000, 3'b000, 3'b111);
    push("wrap_b", 3'b111, 32'h40c, 3'b000, 3'b001, 3'b111);
    push("wrap_c", 3'b001, 32'h418, 3'b000, 3'b001, 3'b111);
    push("wrap_d", 3'b111, 32'h41c, 3'b000, 3'b011, 3'b111);
    push("wrap_full", 3'b111, 32'h428, 3'b000, 3'b000, 3'b111);
    repeat (3) idle("wrap_drain", 3'b111, 3'b111);

    push("flush_a", 3'b111, 32'h500, 3'b000, 3'b000, 3'b111);
    push("flush_b", 3'b001, 32'h50c, 3'b000, 3'b000, 3'b111);
    drive("flush", 1'b1, 1'b1, 3'b111, mk(32'h600, 0), mk(32'h604, 0),
          mk(32'h608, 0), 3'b111, 3'b111);
    idle("after_flush", 3'b111, 3'b111);

    push("mrst_a", 3'b111, 32'h700, 3'b000, 3'b000, 3'b111);
    push("mrst_b", 3'b011, 32'h70c, 3'b000, 3'b000, 3'b111);
    drive("mid_rst", 1'b0, 1'b0, 3'b111, mk(32'h800, 0), mk(32'h804, 0),
          mk(32'h808, 0), 3'b000, 3'b111);
    idle("after_mrst", 3'b111, 3'b111);

    for (int c = 0; c < 2000; c++) begin
      k = $urandom_range(0, 3);
      drive("rand", ($urandom_range(0, 99) != 0), ($urandom_range(0, 39) == 0),
            3'((1 << k) - 1),
            mk($urandom, 1'($urandom)), mk($urandom, 1'($urandom)),
            mk($urandom, 1'($urandom)),
            3'($urandom), 3'($urandom));
    end
    repeat (4) idle("final_drain", 3'b111, 3'b111);

    drv_done = 1;
    repeat (50) begin
      if (!mon_done) @(negedge clk);
    end
    if (!mon_done) begin
      mismatched++;
      $display("FAIL monitor_end: done %0d expected 1", mon_done);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/decode_rename_buffer.md
DECODE_RENAME_BUFFER -- requirements
Module: decode_rename_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, buffer entries; power of two, >= 4.
REQ-002 SHALL have parameter PC_WIDTH, default 32, width of the carried program counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush, active-high.
REQ-006 SHALL have port in_valid  input  3  decoder slot valids; contiguous from bit 0.
REQ-007 SHALL have ports in_entry_0/1/2  input  rename_entry_t  decoded payload: rs1_arch[5], rs2_arch[5], rd_arch[5], rd_write_enable, branch, load_store, pc[PC_WIDTH].
REQ-008 SHALL have port in_ready  output  1  buffer accepts a full 3-wide group this cycle.
REQ-009 SHALL have ports out_entry_0/1/2  output  rename_entry_t  three oldest entries, oldest in slot 0.
REQ-010 SHALL have port out_valid  output  3  granted slots; drives RAT decode_valid; contiguous from bit 0.
REQ-011 SHALL have port rename_ready  input  3  physical-register availability mask from RAT.
REQ-012 SHALL have port lsq_alloc_ready  input  3  LSQ-slot availability mask from RAT.
REQ-013 SHALL have port occupancy  output  $clog2(DEPTH)+1  current entry count.
REQ-014 SHALL have ports empty, full  output  1 each  occupancy==0 / occupancy==DEPTH.

Function
REQ-015 SHALL store entries in an in-order circular array with head (read) and tail (write) pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-016 SHALL drive in_ready = (DEPTH - occupancy) >= 3, from registered occupancy only (no dependency on same-cycle pop).
REQ-017 SHALL, when in_ready=1 and flush=0, write in_entry_0..k-1 at tail..tail+k-1 (mod DEPTH), k = popcount(in_valid); in_valid ignored when in_ready=0.
REQ-018 SHALL present out_entry_i = array[head+i mod DEPTH] regardless of validity.
REQ-019 SHALL set out_valid[i]=1 iff i<occupancy, rename_ready[i]=1, number of load_store entries among slots 0..i <= popcount(lsq_alloc_ready), out_valid[i-1]=1 (i>0), and flush=0.
REQ-020 SHALL advance head by p = popcount(out_valid) each cycle; out_valid is both grant and pop, no separate acknowledge.
REQ-021 SHALL update occupancy_next = occupancy + k - p when both push and pop occur in the same cycle.
REQ-022 SHALL make a written entry visible on out_* no earlier than the cycle after it is written; no input-to-output bypass.
REQ-023 SHALL, on flush=1, force out_valid=0 that cycle, drop that cycle's push, and set head=tail=0, occupancy=0 at the next edge.
REQ-024 SHALL give flush priority over push and pop; reset has priority over flush.
REQ-025 SHALL flag non-contiguous in_valid or out_valid via a simulation-only assertion.

Reset
REQ-026 SHALL, with reset=0 at a rising edge, set head=0, tail=0, occupancy=0, so that out_valid=0, empty=1, full=0, in_ready=1 from the following cycle.
REQ-027 SHALL leave entry storage unreset; out_entry_* content is don't-care while out_valid=0.
REQ-028 SHALL treat reset asserted mid-operation identically to REQ-026, discarding all entries and that cycle's push.

Structure
REQ-029 SHALL take rename_entry_t and ARCH_ADDR_WIDTH=5 from the shared package issue_stage_pkg, which the rename and dispatch blocks also use.
REQ-030 SHALL be a single module with no sub-modules; popcount and LSQ-prefix logic stay inline.

Verification
REQ-031 Reset, then push 3 entries (pc 0x100/104/108), rename_ready=111, lsq_alloc_ready=111 -> out_valid=111 the next cycle with pcs in order, occupancy back to 0.
REQ-032 Buffer holds 3, rename_ready=001 -> out_valid=001, occupancy 3->2; then rename_ready=000 -> out_valid=000, no change.
REQ-033 Slots load, ALU, load; lsq_alloc_ready=001; rename_ready=111 -> out_valid=011, slot 2 stays at head.
REQ-034 DEPTH=8, occupancy 6 -> in_ready=0, push ignored; pop 2 plus push 3 same cycle from occupancy 5 -> occupancy 6, tail wraps 7->2.
REQ-035 Occupancy 4 with in_valid=111 and flush=1 -> out_valid=000 that cycle; next cycle occupancy 0, empty=1, and none of the pushed pcs appear.
REQ-036 reset=0 while occupancy=5 with push pending -> next cycle occupancy 0, in_ready=1, out_valid=000.
